fpcvt_seq: RTL and testbench
============================

Name: fpcvt_seq

Overview:
- Parametrised, multi-cycle successor to the combinational fpcvt converter.
- Converts a DW-bit two's-complement sample into sign / EW-bit exponent / FW-bit significand, where value = F * 2^E, with round-to-nearest.
- Normalisation is iterative (one shift per clock), so the block is small for wide inputs.
- Sits between a sample producer and a consumer, using valid/ready handshakes on both sides.

Parameters:
- DW, 12, input width. Must satisfy DW == FW + 2**EW; any other value is an elaboration error.
- EW, 3, exponent width. EMAX = 2**EW - 1.
- FW, 4, significand width.

Ports:
- clk  in  1  clock; all registers update on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  d is valid.
- in_ready  out  1  block can accept d. High only in IDLE.
- d  in  DW  two's-complement input sample.
- out_valid  out  1  s/e/f hold a completed result.
- out_ready  in  1  consumer accepts the result.
- s  out  1  sign.
- e  out  EW  exponent.
- f  out  FW  significand.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, s=0, e=0, f=0, internal mag/exp cleared. Any in-flight conversion is discarded.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch s=d[DW-1].
  - mag (DW-1 bits) = |d|. d = -2^(DW-1) saturates to 2^(DW-1)-1.
  - exp=EMAX. Go to NORM.
- NORM: each cycle:
  - if exp==0 or mag[DW-2]==1, go to ROUND.
  - else mag<<=1 (shift in 0) and exp-=1.
- ROUND:
  - F0=mag[DW-2 -: FW], r=mag[DW-2-FW].
  - r==0: f=F0, e=exp.
  - r==1 and F0 != all-ones: f=F0+1, e=exp.
  - r==1, F0 all-ones, exp<EMAX: f=1 followed by FW-1 zeros, e=exp+1.
  - r==1, F0 all-ones, exp==EMAX: saturate to f=all-ones, e=EMAX.
  - Register s/e/f, go to DONE.
- DONE: out_valid=1; s/e/f held stable. On out_ready, go to IDLE next edge; out_valid drops and in_ready rises. No new input is accepted in the same cycle as an output handshake.
- Latency: with k = number of shifts (0..EMAX), out_valid rises k+2 edges after the acceptance edge. Worst case is EMAX+2 (9 for defaults). Throughput is one sample per (k+3) cycles minimum.
- Zero input: k=EMAX, result s=0, e=0, f=0.
- After EMAX shifts the round bit is a shifted-in 0, so exp==0 results are exact.
- s/e/f change only on entry to DONE or on reset. Between results they retain the last value.
- in_valid while busy is ignored (in_ready=0). d need not be held after acceptance.
- out_ready while not in DONE has no effect.

Decomposition:
- Shared package/include fpcvt_pkg:
  - state encoding localparams (IDLE=0, NORM=1, ROUND=2, DONE=3).
  - EMAX derivation.
  - DW/EW/FW consistency check macro.
- One combinational sub-module, fpcvt_round:
  - inputs F0, r, exp; outputs f, e.
  - implements the rounding, overflow-renormalise and saturation rules.
  - reused later by the existing combinational converter.
- FSM, magnitude and shifter stay in fpcvt_seq.

Test Plan:
- d=12'd422, out_ready=1 -> s=0, e=3'b101, f=4'b1101, out_valid exactly 4 cycles after acceptance.
- d=-12'd2048 -> saturated magnitude 2047 rounds up past all-ones at exp 7 -> s=1, e=3'b111, f=4'b1111, latency 2.
- d=12'd0, then d=-12'd1 -> (s=0,e=0,f=0) and (s=1,e=0,f=4'b0001), each with latency 9.
- d=12'd125 (0000_0111_1101) -> k=4, F0=1111, r=1 -> renormalise: s=0, e=3'b100, f=4'b1000.
- Hold out_ready=0 for 5 cycles in DONE, toggling in_valid with new d -> out_valid stays 1, s/e/f stable, in_ready=0, no second sample accepted. Raise out_ready -> IDLE next edge.
- Assert rst_n=0 asynchronously mid-NORM after accepting d=12'd422 -> immediately out_valid=0, s=e=f=0, in_ready=1. After release, a new d=12'd422 converts normally.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared definitions for the fpcvt converter family: state encoding,
// exponent range derivation and a parameter-consistency check.
`ifndef FPCVT_PKG_SV
`define FPCVT_PKG_SV

// Placed in a generate context; fails elaboration unless DW == FW + 2**EW.
`define FPCVT_CHECK_CFG(DW_, EW_, FW_) \
  if ((DW_) != (FW_) + (1 << (EW_))) begin : g_bad_cfg \
    $error("fpcvt: DW must equal FW + 2**EW"); \
  end

package fpcvt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int emax(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

`endif

// File: rtl/fpcvt_round.sv
// Round-to-nearest of a normalised significand, with renormalisation on
// carry-out and saturation at the top exponent.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic [FW-1:0] f0,
  input  logic          r,
  input  logic [EW-1:0] exp,
  output logic [FW-1:0] f,
  output logic [EW-1:0] e
);

  localparam logic [EW-1:0] EMAX = EW'(emax(EW));

  always_comb begin
    f = f0;
    e = exp;
    if (r) begin
      if (f0 != '1) begin
        f = f0 + 1'b1;
      end else if (exp != EMAX) begin
        // carry out of the significand: 1.000 at the next exponent
        f = {1'b1, {(FW-1){1'b0}}};
        e = exp + 1'b1;
      end else begin
        f = '1;
        e = EMAX;
      end
    end
  end

endmodule

// File: rtl/fpcvt_seq.sv
// Multi-cycle two's-complement to sign/exponent/significand converter.
// Normalises one bit per clock, then rounds; valid/ready on both sides.
module fpcvt_seq
  import fpcvt_pkg::*;
#(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          s,
  output logic [EW-1:0] e,
  output logic [FW-1:0] f
);

  `FPCVT_CHECK_CFG(DW, EW, FW)

  localparam logic [EW-1:0] EMAX = EW'(emax(EW));

  state_t        state, state_n;
  logic [DW-2:0] mag;
  logic [EW-1:0] exp;
  logic          sgn;
  logic [DW-1:0] d_neg;
  logic [DW-2:0] mag_in;
  logic          norm_done;
  logic [FW-1:0] rnd_f;
  logic [EW-1:0] rnd_e;

  // Only -2^(DW-1) keeps its MSB after negation; clamp it to the largest magnitude.
  assign d_neg     = ~d + 1'b1;
  assign mag_in    = !d[DW-1] ? d[DW-2:0] : (d_neg[DW-1] ? '1 : d_neg[DW-2:0]);
  assign norm_done = (exp == '0) || mag[DW-2];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  fpcvt_round #(.EW(EW), .FW(FW)) u_round (
    .f0  (mag[DW-2 -: FW]),
    .r   (mag[DW-2-FW]),
    .exp (exp),
    .f   (rnd_f),
    .e   (rnd_e)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (in_valid)  state_n = NORM;
      NORM:  if (norm_done) state_n = ROUND;
      ROUND:                state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
      exp <= '0;
      sgn <= 1'b0;
      s   <= 1'b0;
      e   <= '0;
      f   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sgn <= d[DW-1];
          mag <= mag_in;
          exp <= EMAX;
        end
        NORM: if (!norm_done) begin
          mag <= {mag[DW-3:0], 1'b0};
          exp <= exp - 1'b1;
        end
        ROUND: begin
          s <= sgn;
          e <= rnd_e;
          f <= rnd_f;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq: directed cases, handshake hold,
// asynchronous reset mid-conversion and randomized samples against a model.
module tb_fpcvt_seq;

  localparam int DW = 12;
  localparam int EW = 3;
  localparam int FW = 4;
  localparam int EMAXV = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] d = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          s;
  logic [EW-1:0] e;
  logic [FW-1:0] f;

  int checks = 0;
  int errors = 0;

  fpcvt_seq #(.DW(DW), .EW(EW), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .e         (e),
    .f         (f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // value = F * 2^E from the sample's magnitude, by plain integer arithmetic
  task automatic model(input logic [DW-1:0] dv, output int ms, output int me,
                       output int mf, output int mlat);
    int v, m, k, sc, fr, rb, ex;
    v  = int'($signed(dv));
    ms = int'(dv[DW-1]);
    m  = (v < 0) ? -v : v;
    if (m > (1 << (DW-1)) - 1) m = (1 << (DW-1)) - 1;
    k = 0;
    while (k < EMAXV && (m << k) < (1 << (DW-2))) k++;
    sc = m << k;
    fr = sc >> (DW-1-FW);
    rb = (sc >> (DW-2-FW)) & 1;
    ex = EMAXV - k;
    fr = fr + rb;
    if (fr == (1 << FW)) begin
      if (ex < EMAXV) begin
        fr = 1 << (FW-1);
        ex = ex + 1;
      end else begin
        fr = (1 << FW) - 1;
      end
    end
    me = ex;
    mf = fr;
    mlat = k + 2;
  endtask

  // Present a sample, then count edges until out_valid (bounded).
  task automatic accept(input logic [DW-1:0] dv, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    d = dv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    d = DW'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [DW-1:0] dv);
    int lat, ms, me, mf, ml;
    model(dv, ms, me, mf, ml);
    accept(dv, lat);
    chk({tag, "_lat"}, lat, ml);
    chk({tag, "_s"}, s, ms);
    chk({tag, "_e"}, e, me);
    chk({tag, "_f"}, f, mf);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_vld"}, out_valid, 0);
  endtask

  initial begin
    int lat, ms, me, mf, ml;
    logic [EW-1:0] he;
    logic [FW-1:0] hf;
    logic          hs;

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sef", {s, e, f}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed: explicit expected values from hand calculation
    accept(12'd422, lat);
    chk("d422_lat", lat, 4);
    chk("d422_sef", {s, e, f}, {1'b0, 3'b101, 4'b1101});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    accept(12'h800, lat);
    chk("dmin_lat", lat, 2);
    chk("dmin_sef", {s, e, f}, {1'b1, 3'b111, 4'b1111});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    accept(12'd0, lat);
    chk("dzero_lat", lat, 9);
    chk("dzero_sef", {s, e, f}, 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    accept(12'hFFF, lat);
    chk("dm1_lat", lat, 9);
    chk("dm1_sef", {s, e, f}, {1'b1, 3'b000, 4'b0001});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    convert("d125", 12'd125);
    convert("dmax", 12'd2047);
    convert("dneg125", -12'sd125);

    // hold DONE with out_ready low while in_valid toggles
    accept(12'd125, lat);
    chk("hold_first_sef", {s, e, f}, {1'b0, 3'b100, 4'b1000});
    hs = s; he = e; hf = f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      d = DW'($urandom);
      @(posedge clk); #1;
      chk("hold_vld", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
      chk("hold_sef", {s, e, f}, {hs, he, hf});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release_vld", out_valid, 0);
    chk("hold_release_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_no_second", out_valid, 0);
    end

    // asynchronous reset in the middle of normalisation
    @(negedge clk);
    in_valid = 1'b1;
    d = 12'd422;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_rdy", in_ready, 1);
    chk("arst_sef", {s, e, f}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    convert("after_rst", 12'd422);

    // randomized samples against the model
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] rv;
      rv = DW'($urandom);
      if (i % 4 == 0) rv = DW'($urandom_range(0, 63));
      if (i % 4 == 1) rv = -DW'($urandom_range(0, 63));
      convert("rand", rv);
    end

    model(12'd422, ms, me, mf, ml);
    chk("model_sanity", {ms[0], me[EW-1:0], mf[FW-1:0]}, {1'b0, 3'b101, 4'b1101});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
